// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, fed by the ROB commit port.
// Operand reads are combinational with a same-cycle commit bypass.
module reg_file #(
  parameter int unsigned REG_NUM        = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ROB_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clr,
  input  logic                    issue_to_reg_enable,
  input  logic [4:0]              issue_to_reg_rd,
  input  logic [ROB_ADDR_WIDTH:0] issue_to_reg_rob_pos,
  input  logic                    rob_to_reg_enable,
  input  logic [4:0]              rob_to_reg_rd,
  input  logic [DATA_WIDTH-1:0]   rob_to_reg_val,
  input  logic [ROB_ADDR_WIDTH:0] commit_rob_pos,
  input  logic [4:0]              dc_to_reg_rs1_pos,
  input  logic [4:0]              dc_to_reg_rs2_pos,
  output logic [DATA_WIDTH-1:0]   reg_to_dc_rs1_val,
  output logic [ROB_ADDR_WIDTH:0] reg_to_dc_rs1_rob_pos,
  output logic [DATA_WIDTH-1:0]   reg_to_dc_rs2_val,
  output logic [ROB_ADDR_WIDTH:0] reg_to_dc_rs2_rob_pos
);

  logic [DATA_WIDTH-1:0]   regs_q [REG_NUM];
  logic [ROB_ADDR_WIDTH:0] tags_q [REG_NUM];

  logic commit_hit;
  logic issue_hit;

  assign commit_hit = rob_to_reg_enable && (rob_to_reg_rd != 5'd0);
  assign issue_hit  = issue_to_reg_enable && (issue_to_reg_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
        tags_q[i] <= '0;
      end
    end else if (clr) begin
      // Rollback drops every rename, but a commit on the same edge (JALR) still lands.
      for (int i = 0; i < int'(REG_NUM); i++) begin
        tags_q[i] <= '0;
      end
      if (commit_hit) begin
        regs_q[rob_to_reg_rd] <= rob_to_reg_val;
      end
    end else if (rdy) begin
      if (commit_hit) begin
        regs_q[rob_to_reg_rd] <= rob_to_reg_val;
        if (tags_q[rob_to_reg_rd] == commit_rob_pos) begin
          tags_q[rob_to_reg_rd] <= '0;
        end
      end
      // Placed after the commit so a same-rd issue tag overrides the retire.
      if (issue_hit) begin
        tags_q[issue_to_reg_rd] <= issue_to_reg_rob_pos;
      end
    end
  end

  always_comb begin
    reg_to_dc_rs1_val     = regs_q[dc_to_reg_rs1_pos];
    reg_to_dc_rs1_rob_pos = tags_q[dc_to_reg_rs1_pos];
    if (dc_to_reg_rs1_pos == 5'd0) begin
      reg_to_dc_rs1_val     = '0;
      reg_to_dc_rs1_rob_pos = '0;
    end else if (commit_hit && (rob_to_reg_rd == dc_to_reg_rs1_pos) &&
                 (tags_q[dc_to_reg_rs1_pos] == commit_rob_pos)) begin
      reg_to_dc_rs1_val     = rob_to_reg_val;
      reg_to_dc_rs1_rob_pos = '0;
    end
  end

  always_comb begin
    reg_to_dc_rs2_val     = regs_q[dc_to_reg_rs2_pos];
    reg_to_dc_rs2_rob_pos = tags_q[dc_to_reg_rs2_pos];
    if (dc_to_reg_rs2_pos == 5'd0) begin
      reg_to_dc_rs2_val     = '0;
      reg_to_dc_rs2_rob_pos = '0;
    end else if (commit_hit && (rob_to_reg_rd == dc_to_reg_rs2_pos) &&
                 (tags_q[dc_to_reg_rs2_pos] == commit_rob_pos)) begin
      reg_to_dc_rs2_val     = rob_to_reg_val;
      reg_to_dc_rs2_rob_pos = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, bypass, rollback, x0 and stall behaviour.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        issue_to_reg_enable;
  logic [4:0]  issue_to_reg_rd;
  logic [4:0]  issue_to_reg_rob_pos;
  logic        rob_to_reg_enable;
  logic [4:0]  rob_to_reg_rd;
  logic [31:0] rob_to_reg_val;
  logic [4:0]  commit_rob_pos;
  logic [4:0]  dc_to_reg_rs1_pos;
  logic [4:0]  dc_to_reg_rs2_pos;
  logic [31:0] reg_to_dc_rs1_val;
  logic [4:0]  reg_to_dc_rs1_rob_pos;
  logic [31:0] reg_to_dc_rs2_val;
  logic [4:0]  reg_to_dc_rs2_rob_pos;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .clr                   (clr),
    .issue_to_reg_enable   (issue_to_reg_enable),
    .issue_to_reg_rd       (issue_to_reg_rd),
    .issue_to_reg_rob_pos  (issue_to_reg_rob_pos),
    .rob_to_reg_enable     (rob_to_reg_enable),
    .rob_to_reg_rd         (rob_to_reg_rd),
    .rob_to_reg_val        (rob_to_reg_val),
    .commit_rob_pos        (commit_rob_pos),
    .dc_to_reg_rs1_pos     (dc_to_reg_rs1_pos),
    .dc_to_reg_rs2_pos     (dc_to_reg_rs2_pos),
    .reg_to_dc_rs1_val     (reg_to_dc_rs1_val),
    .reg_to_dc_rs1_rob_pos (reg_to_dc_rs1_rob_pos),
    .reg_to_dc_rs2_val     (reg_to_dc_rs2_val),
    .reg_to_dc_rs2_rob_pos (reg_to_dc_rs2_rob_pos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst                  = 1'b0;
    rdy                  = 1'b1;
    clr                  = 1'b0;
    issue_to_reg_enable  = 1'b0;
    issue_to_reg_rd      = '0;
    issue_to_reg_rob_pos = '0;
    rob_to_reg_enable    = 1'b0;
    rob_to_reg_rd        = '0;
    rob_to_reg_val       = '0;
    commit_rob_pos       = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] pos);
    issue_to_reg_enable  = 1'b1;
    issue_to_reg_rd      = rd;
    issue_to_reg_rob_pos = pos;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] val, input logic [4:0] pos);
    rob_to_reg_enable = 1'b1;
    rob_to_reg_rd     = rd;
    rob_to_reg_val    = val;
    commit_rob_pos    = pos;
  endtask

  // Reads the register through both ports and checks value and tag on each.
  task automatic read_chk(input string tag, input logic [4:0] rs,
                          input logic [31:0] exp_val, input logic [4:0] exp_tag);
    dc_to_reg_rs1_pos = rs;
    dc_to_reg_rs2_pos = rs;
    #1;
    check({tag, ".rs1_val"}, reg_to_dc_rs1_val, exp_val);
    check({tag, ".rs1_tag"}, {27'd0, reg_to_dc_rs1_rob_pos}, {27'd0, exp_tag});
    check({tag, ".rs2_val"}, reg_to_dc_rs2_val, exp_val);
    check({tag, ".rs2_tag"}, {27'd0, reg_to_dc_rs2_rob_pos}, {27'd0, exp_tag});
  endtask

  initial begin
    idle();
    dc_to_reg_rs1_pos = '0;
    dc_to_reg_rs2_pos = '0;
    rst = 1'b1;
    tick();
    tick();
    idle();
    read_chk("reset_x5", 5'd5, 32'h0, 5'h00);
    read_chk("reset_x31", 5'd31, 32'h0, 5'h00);

    // 1: commit with tag 0 on an untagged register
    commit(5'd5, 32'h1234, 5'h00);
    tick();
    idle();
    read_chk("t1_x5", 5'd5, 32'h1234, 5'h00);

    // 2: rename then matching commit
    issue(5'd3, 5'h12);
    tick();
    idle();
    read_chk("t2_x3_pending", 5'd3, 32'h0, 5'h12);
    commit(5'd3, 32'hAA, 5'h12);
    tick();
    idle();
    read_chk("t2_x3_done", 5'd3, 32'hAA, 5'h00);

    // 3: older commit must not retire the younger tag, and must not bypass
    issue(5'd3, 5'h12);
    tick();
    issue(5'd3, 5'h13);
    tick();
    idle();
    commit(5'd3, 32'h55, 5'h12);
    read_chk("t3_no_bypass", 5'd3, 32'hAA, 5'h13);
    tick();
    idle();
    read_chk("t3_x3", 5'd3, 32'h55, 5'h13);

    // 4: same-cycle commit bypass to the decoder
    issue(5'd7, 5'h14);
    tick();
    idle();
    commit(5'd7, 32'h99, 5'h14);
    read_chk("t4_bypass", 5'd7, 32'h99, 5'h00);
    tick();
    idle();
    read_chk("t4_x7", 5'd7, 32'h99, 5'h00);

    // Issue and commit on the same rd: value written, new tag kept, no issue bypass
    issue(5'd8, 5'h15);
    tick();
    idle();
    commit(5'd8, 32'h77, 5'h15);
    issue(5'd8, 5'h16);
    read_chk("same_rd_read", 5'd8, 32'h77, 5'h00);
    tick();
    idle();
    read_chk("same_rd_after", 5'd8, 32'h77, 5'h16);

    // Valid bit is part of the compare: 0x03 does not match 0x13
    issue(5'd11, 5'h13);
    tick();
    idle();
    commit(5'd11, 32'h1, 5'h03);
    tick();
    idle();
    read_chk("msb_compare", 5'd11, 32'h1, 5'h13);

    // 5: rollback with JALR commit and an ignored issue
    issue(5'd1, 5'h11);
    tick();
    issue(5'd2, 5'h12);
    tick();
    issue(5'd4, 5'h18);
    tick();
    idle();
    clr = 1'b1;
    commit(5'd1, 32'h100, 5'h11);
    issue(5'd9, 5'h19);
    tick();
    idle();
    read_chk("t5_x1", 5'd1, 32'h100, 5'h00);
    read_chk("t5_x2", 5'd2, 32'h0, 5'h00);
    read_chk("t5_x4", 5'd4, 32'h0, 5'h00);
    read_chk("t5_x8", 5'd8, 32'h77, 5'h00);
    read_chk("t5_x9", 5'd9, 32'h0, 5'h00);

    // 6: x0 is never written or tagged
    issue(5'd0, 5'h1A);
    commit(5'd0, 32'hDEAD, 5'h00);
    tick();
    idle();
    read_chk("t6_x0", 5'd0, 32'h0, 5'h00);

    // 6: rdy=0 freezes state
    issue(5'd6, 5'h1B);
    tick();
    idle();
    rdy = 1'b0;
    commit(5'd6, 32'h66, 5'h1B);
    issue(5'd10, 5'h1C);
    tick();
    tick();
    idle();
    rdy = 1'b0;
    read_chk("t6_hold_x6", 5'd6, 32'h0, 5'h1B);
    read_chk("t6_hold_x10", 5'd10, 32'h0, 5'h00);
    rdy = 1'b1;
    commit(5'd6, 32'h66, 5'h1B);
    tick();
    idle();
    read_chk("t6_resume_x6", 5'd6, 32'h66, 5'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
